// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the single-issue core.
// Registers the next PC from jump/branch strobes, inserts a one-cycle
// squash bubble after every taken redirect, registers the JAL link write
// and parks the core in HALTED on a syscall-halt strobe.
// Optional feature macro: BRANCH_COUNT_EN adds out_taken_cnt, a saturating
// count of taken redirects accepted in RUN.
module pc_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_stall,
    input  logic              in_halt,
    input  logic              in_J,
    input  logic              in_JW,
    input  logic              in_JR,
    input  logic              in_BEQ,
    input  logic              in_BNE,
    input  logic              in_BGEZ,
    input  logic              in_eq,
    input  logic              in_rs_neg,
    input  logic [ADDR_W-1:0] in_rs_val,
    input  logic [15:0]       in_imm16,
    input  logic [25:0]       in_target26,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc_plus4,
    output logic              out_flush,
    output logic              out_link_we,
    output logic [ADDR_W-1:0] out_link_val,
    output logic              out_halted
`ifdef BRANCH_COUNT_EN
    ,
    output logic [15:0]       out_taken_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] branch_target;
    logic              taken;
    logic              run_accept;

    assign out_pc       = pc;
    assign out_pc_plus4 = pc + ADDR_W'(4);

    // An instruction in RUN is acted on only when not stalled and not halting
    assign run_accept = (state == RUN) && !in_stall && !in_halt;

    // Redirect decision and priority-ordered target (JR > J/JW > branches)
    always_comb begin
        taken = in_JR | in_J | in_JW | (in_BEQ & in_eq) | (in_BNE & ~in_eq)
              | (in_BGEZ & ~in_rs_neg);
        branch_target = out_pc_plus4
                      + {{(ADDR_W-18){in_imm16[15]}}, in_imm16, 2'b00};
        if (in_JR) begin
            target = in_rs_val & {{(ADDR_W-2){1'b1}}, 2'b00};
        end else if (in_J || in_JW) begin
            target = {out_pc_plus4[ADDR_W-1:28], in_target26, 2'b00};
        end else begin
            target = branch_target;
        end
    end

    // State register; stall freezes the FSM
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= RUN;
        end else if (!in_stall) begin
            state <= next_state;
        end
    end

    // Next-state logic; halt outranks any redirect in the same cycle
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (in_halt) begin
                    next_state = HALTED;
                end else if (taken) begin
                    next_state = BUBBLE;
                end
            end
            BUBBLE:  next_state = RUN;
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    // State-decoded outputs: squash during the bubble, halted flag in HALTED
    always_comb begin
        out_flush  = 1'b0;
        out_halted = 1'b0;
        case (state)
            BUBBLE:  out_flush  = 1'b1;
            HALTED:  out_halted = 1'b1;
            default: ;
        endcase
    end

    // Next-PC selection; bubble and fall-through both step by one word
    always_comb begin
        next_pc = pc;
        case (state)
            RUN: begin
                if (in_halt) begin
                    next_pc = pc;
                end else if (taken) begin
                    next_pc = target;
                end else begin
                    next_pc = out_pc_plus4;
                end
            end
            BUBBLE:  next_pc = out_pc_plus4;
            default: next_pc = pc;
        endcase
    end

    // PC register
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            pc <= RESET_PC;
        end else if (!in_stall) begin
            pc <= next_pc;
        end
    end

    // Link write for JAL, visible only during the following bubble cycle
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_link_we  <= 1'b0;
            out_link_val <= '0;
        end else if (!in_stall) begin
            out_link_we <= run_accept && in_JW;
            if (run_accept && in_JW) begin
                out_link_val <= out_pc_plus4;
            end
        end
    end

`ifdef BRANCH_COUNT_EN
    // Saturating count of taken redirects accepted in RUN
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_taken_cnt <= '0;
        end else if (run_accept && taken && (out_taken_cnt != 16'hFFFF)) begin
            out_taken_cnt <= out_taken_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// A behavioural model tracks PC, mode, link and (optionally) the taken
// counter from the architectural rules; a negedge process compares every
// cycle, and directed scenarios add literal expectations.
module tb_pc_sequencer;

    localparam int MODE_RUN    = 0;
    localparam int MODE_BUBBLE = 1;
    localparam int MODE_HALT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt, j, jw, jr, beq, bne, bgez, eq, rs_neg;
    logic [31:0] rs_val;
    logic [15:0] imm16;
    logic [25:0] target26;

    logic [31:0] pc, pc_plus4, link_val;
    logic        flush, link_we, halted;
`ifdef BRANCH_COUNT_EN
    logic [15:0] taken_cnt;
`endif

    int          m_mode;
    logic [31:0] m_pc;
    logic        m_link_we;
    logic [31:0] m_link_val;
    logic [15:0] m_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .in_clk      (clk),
        .in_rst_n    (rst_n),
        .in_stall    (stall),
        .in_halt     (halt),
        .in_J        (j),
        .in_JW       (jw),
        .in_JR       (jr),
        .in_BEQ      (beq),
        .in_BNE      (bne),
        .in_BGEZ     (bgez),
        .in_eq       (eq),
        .in_rs_neg   (rs_neg),
        .in_rs_val   (rs_val),
        .in_imm16    (imm16),
        .in_target26 (target26),
        .out_pc      (pc),
        .out_pc_plus4(pc_plus4),
        .out_flush   (flush),
        .out_link_we (link_we),
        .out_link_val(link_val),
        .out_halted  (halted)
`ifdef BRANCH_COUNT_EN
        ,
        .out_taken_cnt(taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_mode     = MODE_RUN;
        m_pc       = 32'h0000_0000;
        m_link_we  = 1'b0;
        m_link_val = 32'h0000_0000;
        m_cnt      = 16'h0000;
    endtask

    // Advance the model by one clock edge using the inputs the DUT saw
    task automatic modelStep();
        logic [31:0] next4;
        logic        is_taken;
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (stall) return;
        next4 = m_pc + 32'd4;
        if (m_mode == MODE_RUN) begin
            if (halt) begin
                m_mode    = MODE_HALT;
                m_link_we = 1'b0;
            end else begin
                is_taken = jr || j || jw || (beq && eq) || (bne && !eq) || (bgez && !rs_neg);
                m_link_we = jw;
                if (jw) m_link_val = next4;
                if (is_taken) begin
                    if (jr)
                        m_pc = rs_val & 32'hFFFF_FFFC;
                    else if (j || jw)
                        m_pc = {next4[31:28], target26, 2'b00};
                    else
                        m_pc = next4 + (32'($signed(imm16)) << 2);
                    m_mode = MODE_BUBBLE;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end else begin
                    m_pc = next4;
                end
            end
        end else if (m_mode == MODE_BUBBLE) begin
            m_pc      = next4;
            m_mode    = MODE_RUN;
            m_link_we = 1'b0;
        end
    endtask

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        checkOutput("pc", pc, m_pc);
        checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
        checkOutput("flush", {31'b0, flush}, {31'b0, m_mode == MODE_BUBBLE});
        checkOutput("link_we", {31'b0, link_we}, {31'b0, m_link_we});
        if (m_link_we) checkOutput("link_val", link_val, m_link_val);
        checkOutput("halted", {31'b0, halted}, {31'b0, m_mode == MODE_HALT});
`ifdef BRANCH_COUNT_EN
        checkOutput("taken_cnt", {16'b0, taken_cnt}, {16'b0, m_cnt});
`endif
    end

    task automatic clearInputs();
        stall = 0; halt = 0; j = 0; jw = 0; jr = 0;
        beq = 0; bne = 0; bgez = 0; eq = 0; rs_neg = 0;
        rs_val = '0; imm16 = '0; target26 = '0;
    endtask

    // One clock edge with the currently driven inputs; returns 1ns after it
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle();
        clearInputs();
        applyStimulus();
    endtask

    // Reach PC = addr in RUN via a JR to addr-4 followed by its bubble
    task automatic goTo(input logic [31:0] addr);
        clearInputs();
        jr = 1; rs_val = addr - 32'd4;
        applyStimulus();
        idle();
    endtask

    task automatic pulseReset();
        rst_n = 0;
        modelReset();
        #1;
        checkOutput("async_reset_pc", pc, 32'h0000_0000);
        checkOutput("async_reset_halted", {31'b0, halted}, 32'd0);
        rst_n = 1;
    endtask

    task automatic randomInputs();
        clearInputs();
        stall    = ($urandom_range(0, 4) == 0);
        halt     = ($urandom_range(0, 149) == 0);
        jr       = ($urandom_range(0, 7) == 0);
        j        = ($urandom_range(0, 7) == 0);
        jw       = !jr && ($urandom_range(0, 7) == 0);
        beq      = ($urandom_range(0, 5) == 0);
        bne      = ($urandom_range(0, 5) == 0);
        bgez     = ($urandom_range(0, 5) == 0);
        eq       = $urandom_range(0, 1) == 1;
        rs_val   = $urandom;
        rs_neg   = rs_val[31];
        imm16    = 16'($urandom);
        target26 = 26'($urandom);
    endtask

    initial begin
        int halt_cycles;
        clearInputs();
        rst_n = 0;
        modelReset();
        #2;
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_flush", {31'b0, flush}, 32'd0);
        checkOutput("reset_link_we", {31'b0, link_we}, 32'd0);
        checkOutput("reset_link_val", link_val, 32'h0);
        checkOutput("reset_halted", {31'b0, halted}, 32'd0);
        rst_n = 1;

        // Sequential fall-through after reset
        idle(); checkOutput("seq_pc1", pc, 32'h4);
        idle(); checkOutput("seq_pc2", pc, 32'h8);
        idle(); checkOutput("seq_pc3", pc, 32'hC);
        checkOutput("seq_flush", {31'b0, flush}, 32'd0);

        // Backward BEQ taken from 0x10
        idle(); checkOutput("at_0x10", pc, 32'h10);
        clearInputs(); beq = 1; eq = 1; imm16 = 16'hFFFE;
        applyStimulus();
        checkOutput("beq_pc", pc, 32'hC);
        checkOutput("beq_flush", {31'b0, flush}, 32'd1);
        idle();
        checkOutput("beq_after_pc", pc, 32'h10);
        checkOutput("beq_after_flush", {31'b0, flush}, 32'd0);

        // BNE not taken
        goTo(32'h20);
        clearInputs(); bne = 1; eq = 1; imm16 = 16'h0040;
        applyStimulus();
        checkOutput("bne_pc", pc, 32'h24);
        checkOutput("bne_flush", {31'b0, flush}, 32'd0);

        // JAL with link
        goTo(32'h3000_0040);
        clearInputs(); jw = 1; target26 = 26'h000_0100;
        applyStimulus();
        checkOutput("jal_pc", pc, 32'h3000_0400);
        checkOutput("jal_link_we", {31'b0, link_we}, 32'd1);
        checkOutput("jal_link_val", link_val, 32'h3000_0044);
        idle();
        checkOutput("jal_after_link_we", {31'b0, link_we}, 32'd0);
        checkOutput("jal_after_pc", pc, 32'h3000_0404);

        // JR beats J, then stall inside the bubble
        clearInputs(); jr = 1; j = 1; rs_val = 32'h0000_1237; target26 = 26'h3FF;
        applyStimulus();
        checkOutput("jr_pc", pc, 32'h1234);
        clearInputs(); stall = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("stall_pc", pc, 32'h1234);
        checkOutput("stall_flush", {31'b0, flush}, 32'd1);
        idle();
        checkOutput("unstall_pc", pc, 32'h1238);
        checkOutput("unstall_flush", {31'b0, flush}, 32'd0);

        // PC wrap and branch-target wrap
        goTo(32'hFFFF_FFFC);
        idle(); checkOutput("wrap_pc", pc, 32'h0);
        goTo(32'hFFFF_FFF0);
        clearInputs(); bgez = 1; rs_neg = 0; imm16 = 16'h0010;
        applyStimulus();
        checkOutput("branch_wrap_pc", pc, 32'h34);
        idle();

        // Halt outranks a taken branch; reset leaves HALTED
        clearInputs(); halt = 1; beq = 1; eq = 1; imm16 = 16'h0005;
        applyStimulus();
        checkOutput("halt_halted", {31'b0, halted}, 32'd1);
        checkOutput("halt_pc", pc, 32'h38);
        checkOutput("halt_flush", {31'b0, flush}, 32'd0);
        clearInputs(); j = 1; target26 = 26'h55;
        applyStimulus();
        checkOutput("halt_frozen_pc", pc, 32'h38);
        pulseReset();

        // Randomized traffic against the model
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            randomInputs();
            applyStimulus();
            if (m_mode == MODE_HALT) halt_cycles++;
            if (halt_cycles > 4) begin
                pulseReset();
                halt_cycles = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                pulseReset();
            end
        end

        clearInputs();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: run did not complete, %0d compared", n_cmp);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
